// File: rtl/hidden_layer_seq.sv
// Hidden-layer sequencer: walks weight ROM and pixel memory per neuron,
// drives MAC clear/enable and hands each neuron's sum downstream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a layer pass (honoured only when idle)
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   w_addr, x_addr    registered ROM and pixel-memory addresses
//   mac_clr, mac_en   accumulator clear / accumulate strobes
//   res_valid, res_ready, res_idx  result handshake and neuron index
module hidden_layer_seq #(
  parameter int NUM_IN   = 784,
  parameter int NUM_HID  = 32,
  parameter int W_ADDR_W = 15,
  parameter int X_ADDR_W = 10,
  parameter int IDX_W    = 5,
  parameter int ROM_LAT  = 1,
  parameter int MAC_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic [X_ADDR_W-1:0] x_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDX_W-1:0]    res_idx
);

  typedef enum logic [2:0] {
    IDLE, CLR, RUN, DRAIN, WAIT, FIN
  } state_t;

  localparam int DR   = ROM_LAT + MAC_LAT;
  localparam int DC_W = $clog2(DR + 1);

  localparam logic [X_ADDR_W-1:0] X_LAST =
    X_ADDR_W'(NUM_IN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_HID - 1);
  localparam logic [W_ADDR_W-1:0] W_STEP =
    W_ADDR_W'(NUM_IN);
  localparam logic [DC_W-1:0] D_LAST =
    DC_W'(DR - 1);

  state_t state, nxt;

  logic [W_ADDR_W-1:0] base;
  logic [DC_W-1:0]     dcnt;
  logic [ROM_LAT-1:0]  issue;

  // issue flag trails RUN by the memory latency
  assign mac_en = issue[ROM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b1;
    done      = 1'b0;
    mac_clr   = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = CLR;
      end
      CLR: begin
        mac_clr = 1'b1;
        nxt     = RUN;
      end
      RUN: begin
        if (x_addr == X_LAST) nxt = DRAIN;
      end
      DRAIN: begin
        if (dcnt == D_LAST) nxt = WAIT;
      end
      WAIT: begin
        res_valid = 1'b1;
        if (res_ready)
          nxt = (res_idx == IDX_LAST) ? FIN : CLR;
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr  <= '0;
      x_addr  <= '0;
      res_idx <= '0;
      base    <= '0;
      dcnt    <= '0;
      issue   <= '0;
    end else begin
      issue[0] <= (state == RUN);
      for (int k = 1; k < ROM_LAT; k++)
        issue[k] <= issue[k-1];
      case (state)
        IDLE: begin
          if (start) begin
            base    <= '0;
            res_idx <= '0;
          end
        end
        CLR: begin
          w_addr <= base;
          x_addr <= '0;
          dcnt   <= '0;
        end
        RUN: begin
          // last address is held through DRAIN/WAIT
          if (x_addr != X_LAST) begin
            w_addr <= w_addr + W_ADDR_W'(1);
            x_addr <= x_addr + X_ADDR_W'(1);
          end
        end
        DRAIN: dcnt <= dcnt + DC_W'(1);
        WAIT: begin
          if (res_ready && res_idx != IDX_LAST) begin
            base    <= base + W_STEP;
            res_idx <= res_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq: default build plus a small
// ROM_LAT=2 build, each with a ROM model and reference MAC.
module tb_hidden_layer_seq;

  localparam int NI = 784;
  localparam int NH = 32;
  localparam int BI = 8;
  localparam int BH = 4;

  logic clk = 1'b0;
  logic rst, start, res_ready;
  logic busy, done, mac_clr, mac_en, res_valid;
  logic [14:0] w_addr;
  logic [9:0]  x_addr;
  logic [4:0]  res_idx;

  logic start_b, ready_b;
  logic busy_b, done_b, clr_b, en_b, valid_b;
  logic [4:0] w_b;
  logic [2:0] x_b;
  logic [1:0] idx_b;

  hidden_layer_seq #(
    .NUM_IN(NI), .NUM_HID(NH), .W_ADDR_W(15),
    .X_ADDR_W(10), .IDX_W(5), .ROM_LAT(1), .MAC_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .done(done), .w_addr(w_addr), .x_addr(x_addr),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx)
  );

  hidden_layer_seq #(
    .NUM_IN(BI), .NUM_HID(BH), .W_ADDR_W(5),
    .X_ADDR_W(3), .IDX_W(2), .ROM_LAT(2), .MAC_LAT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .done(done_b), .w_addr(w_b), .x_addr(x_b),
    .mac_clr(clr_b), .mac_en(en_b),
    .res_valid(valid_b), .res_ready(ready_b),
    .res_idx(idx_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wf(input int a);
    return (a * 37 + 11) % 17;
  endfunction

  function automatic int xf(input int i);
    return (i * 13 + 5) % 11;
  endfunction

  function automatic longint exp_sum(input int n,
                                     input int ni);
    longint s = 0;
    for (int i = 0; i < ni; i++)
      s += longint'(wf(n * ni + i) * xf(i));
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory models and reference accumulators
  int wq, xq, wb1, wb2, xb1, xb2;
  longint acc, acc_b;

  always @(posedge clk) begin
    wq  <= wf(int'(w_addr));
    xq  <= xf(int'(x_addr));
    wb1 <= wf(int'(w_b));
    xb1 <= xf(int'(x_b));
    wb2 <= wb1;
    xb2 <= xb1;
    if (rst || mac_clr) acc <= 0;
    else if (mac_en) acc <= acc + longint'(wq * xq);
    if (rst || clr_b) acc_b <= 0;
    else if (en_b) acc_b <= acc_b + longint'(wb2 * xb2);
  end

  // monitor for the default build
  int mn = 0, mcnt = 0, ovl = 0, ndone = 0, nres = 0;
  int wmax = 0;
  bit pv = 0, pc1 = 0, pc2 = 0;

  always @(negedge clk) begin
    if (mac_clr && mac_en) ovl++;
    if (clr_b && en_b) ovl++;
    if (mac_clr) mcnt = 0;
    else if (mac_en) mcnt++;
    if (busy && int'(w_addr) > wmax) wmax = int'(w_addr);
    if (done) ndone++;
    if (rst) begin
      mn = 0;
    end else begin
      if (pc1) begin
        chk("first_w", w_addr, mn * NI);
        chk("first_x", x_addr, 0);
        chk("first_idx", res_idx, mn);
        chk("first_en", mac_en, 0);
      end
      if (pc2 && mn == 0) chk("en_lat", mac_en, 1);
      if (res_valid && !pv) begin
        chk("sum", acc, exp_sum(mn, NI));
        chk("en_cnt", mcnt, NI);
        nres++;
      end
      if (res_valid && res_ready)
        mn = (mn == NH - 1) ? 0 : mn + 1;
    end
    pv  = res_valid;
    pc2 = pc1;
    pc1 = mac_clr;
  end

  // monitor for the ROM_LAT=2 build
  int mb = 0, mcb = 0;
  bit pvb = 0, qb1 = 0, qb2 = 0, qb3 = 0;

  always @(negedge clk) begin
    if (clr_b) mcb = 0;
    else if (en_b) mcb++;
    if (rst) begin
      mb = 0;
    end else begin
      if (qb1) chk("b_first_w", w_b, mb * BI);
      if (qb2) chk("b_en_gap1", en_b, 0);
      if (qb3) chk("b_en_gap2", en_b, 1);
      if (valid_b && !pvb) begin
        chk("b_sum", acc_b, exp_sum(mb, BI));
        chk("b_en_cnt", mcb, BI);
      end
      if (valid_b && ready_b)
        mb = (mb == BH - 1) ? 0 : mb + 1;
    end
    pvb = valid_b;
    qb3 = qb2;
    qb2 = qb1;
    qb1 = clr_b;
  end

  int n, s0, wh, xh;
  bit stable;

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    repeat (3) tick();
    chk("rst_ctl",
        {busy, done, mac_clr, mac_en, res_valid}, 0);
    chk("rst_w", w_addr, 0);
    chk("rst_x", x_addr, 0);
    chk("rst_idx", res_idx, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    s0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_first", mac_clr, 1);
    chk("busy_on", busy, 1);

    // stall neuron 2 in WAIT for 50 extra cycles
    n = 0;
    while (res_idx != 2 && n < 3000) begin
      tick(); n++;
    end
    chk("to_n2", n < 3000, 1);
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 1000) begin
      tick(); n++;
    end
    chk("to_wait2", n < 1000, 1);
    chk("wait2_w", w_addr, 3 * NI - 1);
    wh = int'(w_addr);
    xh = int'(x_addr);
    stable = 1'b1;
    repeat (50) begin
      if (res_valid !== 1'b1 || res_idx !== 5'd2 ||
          int'(w_addr) != wh || int'(x_addr) != xh ||
          mac_en !== 1'b0 || mac_clr !== 1'b0)
        stable = 1'b0;
      tick();
    end
    chk("stall_stable", stable, 1);
    res_ready = 1'b1;
    tick();
    chk("rel_clr", mac_clr, 1);
    chk("rel_idx", res_idx, 3);

    // start pulse mid-RUN of neuron 5 is ignored
    n = 0;
    while (!(res_idx == 5 && x_addr == 10) && n < 5000)
    begin
      tick(); n++;
    end
    chk("to_n5", n < 5000, 1);
    chk("n5_w", w_addr, 5 * NI + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_w", w_addr, 5 * NI + 11);
    chk("ign_clr", mac_clr, 0);
    chk("ign_idx", res_idx, 5);

    n = 0;
    while (!done && n < 30000) begin
      tick(); n++;
    end
    chk("to_done", n < 30000, 1);
    chk("done_cyc", cyc - s0, 32 * 788 + 1 + 50);
    chk("fin_busy", busy, 1);
    tick();
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    repeat (5) tick();
    chk("done_once", ndone, 1);
    chk("n_results", nres, NH);
    chk("w_max", wmax, 25087);

    // reset in RUN of neuron 10 aborts the pass
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(res_idx == 10 && x_addr == 100) && n < 10000)
    begin
      tick(); n++;
    end
    chk("to_n10", n < 10000, 1);
    rst = 1'b1;
    tick();
    chk("ab_ctl",
        {busy, done, mac_clr, mac_en, res_valid}, 0);
    chk("ab_w", w_addr, 0);
    chk("ab_x", x_addr, 0);
    chk("ab_idx", res_idx, 0);
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_clr", mac_clr, 1);
    tick();
    chk("rs_w", w_addr, 0);
    chk("rs_idx", res_idx, 0);
    repeat (5) tick();
    chk("ab_no_done", ndone, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // ROM_LAT=2 build: full pass with scoreboard
    s0 = cyc;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 500) begin
      tick(); n++;
    end
    chk("b_to_done", n < 500, 1);
    chk("b_done_cyc", cyc - s0, BH * 13 + 1);
    tick();
    chk("b_post_busy", busy_b, 0);
    chk("clr_en_ovl", ovl, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
Sequencer for the hidden-layer pass of the SNN. It walks the hidden-weight ROM (NUM_HID neurons × NUM_IN inputs, neuron-major) and the input-pixel memory in lockstep. It drives the shared MAC's clear/enable aligned to the ROM read latency. It presents each neuron's finished accumulation to the downstream activation/storage stage with a valid/ready handshake.

Parameters:
NUM_IN, 784, inputs per neuron (x_addr range 0..NUM_IN-1)
NUM_HID, 32, hidden neurons (res_idx range 0..NUM_HID-1)
W_ADDR_W, 15, weight ROM address width (NUM_IN*NUM_HID must be ≤ 2**W_ADDR_W)
X_ADDR_W, 10, input memory address width
IDX_W, 5, neuron index width
ROM_LAT, 1, cycles from address to data at ROM/input-memory output
MAC_LAT, 1, cycles from last mac_en to accumulator result valid

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begin full layer pass; ignored unless IDLE
busy  out  1  high from the cycle after accepted start until the cycle done is asserted (inclusive)
done  out  1  one-cycle pulse after final neuron's result handshake
w_addr  out  W_ADDR_W  hidden-weight ROM address
x_addr  out  X_ADDR_W  input-pixel memory address
mac_clr  out  1  clear MAC accumulator
mac_en  out  1  MAC accumulate (ROM/input data valid this cycle)
res_valid  out  1  accumulator holds finished sum for res_idx
res_ready  in  1  downstream accepts result
res_idx  out  IDX_W  neuron index of current result

Behaviour:
- Reset: state IDLE; busy, done, mac_clr, mac_en, res_valid = 0; w_addr, x_addr, res_idx = 0; internal base = 0; issue pipeline flushed. Reset mid-pass aborts immediately with no done pulse.
- States: IDLE, CLR, RUN, DRAIN, WAIT, FIN.
- IDLE: start=1 → CLR, with base=0 and res_idx=0. start in any other state is ignored.
- CLR (1 cycle): mac_clr=1, i=0 → RUN.
- RUN (NUM_IN cycles): w_addr=base+i, x_addr=i, i increments each cycle. After i=NUM_IN-1 → DRAIN.
- Issue alignment: an issue flag is set on each RUN cycle and delayed ROM_LAT cycles. mac_en equals the delayed flag, so mac_en is high exactly NUM_IN cycles, starting ROM_LAT cycles after the first RUN cycle.
- Address outputs are registered. w_addr/x_addr hold their last value outside RUN.
- DRAIN: lasts ROM_LAT+MAC_LAT cycles (last mac_en occurs inside it) → WAIT.
- WAIT: res_valid=1, res_idx stable.
  - res_ready=1 with res_idx<NUM_HID-1: base += NUM_IN (adder, no multiplier), res_idx += 1 → CLR.
  - res_ready=1 with res_idx=NUM_HID-1 → FIN.
  - res_ready is sampled only in WAIT; a ready asserted early has no effect.
- FIN (1 cycle): done=1, busy=1 → IDLE. busy=0 in IDLE.
- Cycles per neuron with res_ready tied high: 1 + NUM_IN + ROM_LAT + MAC_LAT + 1 = 788 at defaults. Full pass = 32×788 + 1 (FIN) after start.
- Address range: last neuron base = 31×784 = 24304, final w_addr = 25087 (0x61FF). No wrap is ever produced. base resets to 0 each pass.
- mac_clr and mac_en never high in the same cycle.

Test Plan:
- Reset, then start; res_ready=1 → first RUN cycle w_addr=0,x_addr=0; mac_en first high 1 cycle later; exactly 784 mac_en cycles per neuron; res_valid at first neuron with res_idx=0.
- Neuron boundary → neuron 1 first w_addr=784, x_addr=0; neuron 31 w_addr spans 24304..25087; done pulses once, 25217 cycles after start accepted; busy low afterward.
- Hold res_ready=0 for 50 cycles in WAIT → res_valid and res_idx stay constant, no address/mac_en activity; release → advances to next CLR next cycle.
- start pulsed during RUN of neuron 5 → ignored: no restart, base/indices unchanged, single done at end.
- rst asserted in RUN of neuron 10 → next cycle all outputs 0, IDLE. A new start begins at w_addr=0, res_idx=0.
- Scoreboard model: ROM/input memory with ROM_LAT=1 and a reference MAC → each res_valid sum equals Σ w[n*784+i]·x[i]. Rerun with ROM_LAT=2 to confirm the mac_en shift.
